// File: rtl/bitslice_psum_accum.sv
// rtl/bitslice_psum_accum.sv - bit-slice PE sequencer and shifted partial-sum accumulator
// Define PSUM_SAT_EN for a saturating accumulator; the default build wraps modulo 2^ACC_W.
module bitslice_psum_accum #(
  parameter int PSUM_W       = 10,
  parameter int ACC_W        = 32,
  parameter int MAX_ACT_BITS = 8,
  parameter int MAX_WGT_BITS = 8,
  parameter int SEL_W        = 3
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     i_start,
  input  logic [3:0]               i_act_bits,
  input  logic [3:0]               i_wgt_bits,
  input  logic                     i_act_signed,
  input  logic                     i_wgt_signed,
  output logic                     o_issue,
  output logic [SEL_W-1:0]         o_act_sel,
  output logic [SEL_W-1:0]         o_wgt_sel,
  output logic                     o_SignI,
  output logic                     o_SignW,
  input  logic signed [PSUM_W-1:0] i_psum,
  output logic                     o_busy,
  output logic signed [ACC_W-1:0]  o_result,
  output logic                     o_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0] A_MAX = 4'(MAX_ACT_BITS);
  localparam logic [3:0] W_MAX = 4'(MAX_WGT_BITS);

  state_t                    state_q;
  logic [3:0]                a_q, w_q;
  logic                      a_sgn_q, w_sgn_q;
  logic [SEL_W-1:0]          act_q, wgt_q;
  logic                      issue_q, sign_i_q, sign_w_q, busy_q, valid_q;
  logic                      d_issue_q;
  logic [SEL_W:0]            d_shift_q;
  logic signed [ACC_W-1:0]   acc_q, result_q, acc_d;

  logic [3:0]                a_start, w_start;
  logic [SEL_W-1:0]          act_inc, wgt_inc;
  logic                      last_a, last_w;

  always_comb begin
    a_start = i_act_bits;
    if (i_act_bits == 4'd0)       a_start = 4'd1;
    else if (i_act_bits > A_MAX)  a_start = A_MAX;
    w_start = i_wgt_bits;
    if (i_wgt_bits == 4'd0)       w_start = 4'd1;
    else if (i_wgt_bits > W_MAX)  w_start = W_MAX;
  end

  assign act_inc = act_q + SEL_W'(1);
  assign wgt_inc = wgt_q + SEL_W'(1);
  assign last_a  = (4'(act_q) == a_q - 4'd1);
  assign last_w  = (4'(wgt_q) == w_q - 4'd1);

  // Sign flags are registered alongside the indices, so they are derived from the next index.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      a_q      <= 4'd0;
      w_q      <= 4'd0;
      a_sgn_q  <= 1'b0;
      w_sgn_q  <= 1'b0;
      act_q    <= '0;
      wgt_q    <= '0;
      issue_q  <= 1'b0;
      sign_i_q <= 1'b0;
      sign_w_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (i_start) begin
            state_q  <= ISSUE;
            a_q      <= a_start;
            w_q      <= w_start;
            a_sgn_q  <= i_act_signed;
            w_sgn_q  <= i_wgt_signed;
            act_q    <= '0;
            wgt_q    <= '0;
            issue_q  <= 1'b1;
            busy_q   <= 1'b1;
            sign_i_q <= i_act_signed && (a_start == 4'd1);
            sign_w_q <= i_wgt_signed && (w_start == 4'd1);
          end
        end
        ISSUE: begin
          if (!last_w) begin
            wgt_q    <= wgt_inc;
            sign_w_q <= w_sgn_q && (4'(wgt_inc) == w_q - 4'd1);
          end else if (!last_a) begin
            act_q    <= act_inc;
            wgt_q    <= '0;
            sign_i_q <= a_sgn_q && (4'(act_inc) == a_q - 4'd1);
            sign_w_q <= w_sgn_q && (w_q == 4'd1);
          end else begin
            state_q  <= DRAIN;
            act_q    <= '0;
            wgt_q    <= '0;
            issue_q  <= 1'b0;
            sign_i_q <= 1'b0;
            sign_w_q <= 1'b0;
          end
        end
        DRAIN: begin
          state_q  <= DONE;
          valid_q  <= 1'b1;
          result_q <= acc_d;
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PSUM_SAT_EN
  // Wide enough that neither the maximum shift nor the add can overflow before clamping.
  localparam int EXT_W = ACC_W + MAX_ACT_BITS + MAX_WGT_BITS + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EXT_W-1:0] psum_ext, add_ext, sum_ext;

  always_comb begin
    psum_ext = {{(EXT_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum};
    add_ext  = d_issue_q ? (psum_ext <<< d_shift_q) : '0;
    sum_ext  = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q} + add_ext;
    if (sum_ext > SAT_MAX)      acc_d = SAT_MAX[ACC_W-1:0];
    else if (sum_ext < SAT_MIN) acc_d = SAT_MIN[ACC_W-1:0];
    else                        acc_d = sum_ext[ACC_W-1:0];
  end
`else
  logic signed [ACC_W-1:0] psum_ext;

  always_comb begin
    psum_ext = {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum};
    acc_d    = acc_q + (d_issue_q ? (psum_ext <<< d_shift_q) : '0);
  end
`endif

  // Delay stage mirrors the PE output register so shift and psum line up.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      d_issue_q <= 1'b0;
      d_shift_q <= '0;
      acc_q     <= '0;
    end else begin
      d_issue_q <= issue_q;
      d_shift_q <= {1'b0, act_q} + {1'b0, wgt_q};
      if (state_q == IDLE && i_start) acc_q <= '0;
      else if (d_issue_q)             acc_q <= acc_d;
    end
  end

  assign o_issue   = issue_q;
  assign o_act_sel = act_q;
  assign o_wgt_sel = wgt_q;
  assign o_SignI   = sign_i_q;
  assign o_SignW   = sign_w_q;
  assign o_busy    = busy_q;
  assign o_result  = result_q;
  assign o_valid   = valid_q;

endmodule

// File: tb/tb_bitslice_psum_accum.sv
// tb/tb_bitslice_psum_accum.sv - table-driven scoreboard bench for bitslice_psum_accum
module tb_bitslice_psum_accum;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               RSTn;
  logic               i_start, start12;
  logic [3:0]         i_act_bits, i_wgt_bits;
  logic               i_act_signed, i_wgt_signed;
  logic               o_issue, o_SignI, o_SignW, o_busy, o_valid;
  logic [2:0]         o_act_sel, o_wgt_sel;
  logic signed [31:0] o_result;
  logic signed [9:0]  pe_q;

  logic               issue12, si12, sw12, busy12, valid12;
  logic [2:0]         asel12, wsel12;
  logic signed [11:0] res12;
  logic signed [9:0]  psum12;

  bitslice_psum_accum dut (
    .CLK(CLK), .RSTn(RSTn), .i_start(i_start), .i_act_bits(i_act_bits), .i_wgt_bits(i_wgt_bits),
    .i_act_signed(i_act_signed), .i_wgt_signed(i_wgt_signed), .o_issue(o_issue),
    .o_act_sel(o_act_sel), .o_wgt_sel(o_wgt_sel), .o_SignI(o_SignI), .o_SignW(o_SignW),
    .i_psum(pe_q), .o_busy(o_busy), .o_result(o_result), .o_valid(o_valid)
  );

  bitslice_psum_accum #(.ACC_W(12)) dut12 (
    .CLK(CLK), .RSTn(RSTn), .i_start(start12), .i_act_bits(i_act_bits), .i_wgt_bits(i_wgt_bits),
    .i_act_signed(i_act_signed), .i_wgt_signed(i_wgt_signed), .o_issue(issue12),
    .o_act_sel(asel12), .o_wgt_sel(wsel12), .o_SignI(si12), .o_SignW(sw12),
    .i_psum(psum12), .o_busy(busy12), .o_result(res12), .o_valid(valid12)
  );

  typedef struct {
    logic [3:0] ab, wb;
    bit         as_, ws_;
    int         pc, ea, ew, stray;
    longint     er;
  } vec_t;

  int               errors = 0;
  int               checks = 0;
  longint           sb[$];
  longint           last_r;
  int               cur_w;
  bit               use_tab;
  logic signed [9:0] pe_const;
  int               pe_tab[0:63];
  vec_t             vecs[6];
  vec_t             v;

  // PE model: registered psum one cycle after each issue, junk otherwise.
  always @(posedge CLK) begin
    if (o_issue) pe_q <= use_tab ? 10'(pe_tab[int'(o_act_sel) * cur_w + int'(o_wgt_sel)]) : pe_const;
    else         pe_q <= 10'sh155;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t tv, input bit tab, input string nm);
    int cyc, ea, ew, nis;
    bit got;
    longint popped;
    @(negedge CLK);
    chk({nm, "_idle_busy"}, longint'(o_busy), 0);
    i_act_bits = tv.ab; i_wgt_bits = tv.wb;
    i_act_signed = tv.as_; i_wgt_signed = tv.ws_;
    pe_const = 10'(tv.pc); use_tab = tab; cur_w = tv.ew;
    i_start = 1'b1;
    sb.push_back(tv.er);
    @(posedge CLK); #1 i_start = 1'b0;
    cyc = 0; ea = 0; ew = 0; nis = 0; got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        chk({nm, "_busy"}, longint'(o_busy), 1);
        chk({nm, "_hold_result"}, longint'(o_result), last_r);
      end
      if (tv.stray != 0 && cyc == tv.stray)     i_start = 1'b1;
      if (tv.stray != 0 && cyc == tv.stray + 1) i_start = 1'b0;
      if (o_issue) begin
        chk($sformatf("%s_order%0d", nm, nis), longint'({o_act_sel, o_wgt_sel, o_SignI, o_SignW}),
            longint'({3'(ea), 3'(ew), tv.as_ && (ea == tv.ea - 1), tv.ws_ && (ew == tv.ew - 1)}));
        nis++;
        ew++;
        if (ew == tv.ew) begin ew = 0; ea++; end
      end
      if (o_valid) begin
        got = 1'b1;
        chk({nm, "_latency"}, cyc, tv.ea * tv.ew + 2);
        chk({nm, "_issues"}, nis, tv.ea * tv.ew);
        if (sb.size() == 0) chk({nm, "_sb_nonempty"}, 0, 1);
        else begin
          popped = sb.pop_front();
          chk({nm, "_result"}, longint'(o_result), popped);
          last_r = popped;
        end
      end
    end
    i_start = 1'b0;
    if (!got) chk({nm, "_valid_timeout"}, cyc, -1);
  endtask

  initial begin
    int cyc, nis;
    bit sawv;
    longint m;
    logic signed [11:0] t12;

    vecs[0] = '{ab:4'd1, wb:4'd1, as_:0, ws_:0, pc:5,   ea:1, ew:1, stray:0, er:5};
    vecs[1] = '{ab:4'd2, wb:4'd3, as_:1, ws_:1, pc:-1,  ea:2, ew:3, stray:0, er:-21};
    vecs[2] = '{ab:4'd0, wb:4'd15, as_:0, ws_:0, pc:1,  ea:1, ew:8, stray:3, er:255};
    vecs[3] = '{ab:4'd3, wb:4'd2, as_:0, ws_:0, pc:2,   ea:3, ew:2, stray:0, er:42};
    vecs[4] = '{ab:4'd8, wb:4'd8, as_:1, ws_:0, pc:-3,  ea:8, ew:8, stray:0, er:-195075};
    vecs[5] = '{ab:4'd9, wb:4'd1, as_:0, ws_:0, pc:100, ea:8, ew:1, stray:0, er:25500};
    for (int i = 0; i < 64; i++) pe_tab[i] = 0;

    RSTn = 1'b0; i_start = 1'b0; start12 = 1'b0; psum12 = 10'sd511;
    i_act_bits = 4'd0; i_wgt_bits = 4'd0; i_act_signed = 1'b0; i_wgt_signed = 1'b0;
    pe_const = 10'sd0; use_tab = 1'b0; cur_w = 1; last_r = 0;
    repeat (3) @(negedge CLK);
    #1 chk("reset_outputs", longint'({o_issue, o_act_sel, o_wgt_sel, o_SignI, o_SignW, o_busy, o_valid, o_result}), 0);
    @(negedge CLK); RSTn = 1'b1;

    for (int i = 0; i < 6; i++) run(vecs[i], 1'b0, $sformatf("vec%0d", i));

    pe_tab[0] = 1; pe_tab[1] = 2; pe_tab[2] = 3; pe_tab[3] = 4;
    v = '{ab:4'd2, wb:4'd2, as_:0, ws_:0, pc:0, ea:2, ew:2, stray:0, er:27};
    run(v, 1'b1, "ordered2x2");

    // Abort a 4x4 run during its third issue.
    @(negedge CLK);
    i_act_bits = 4'd4; i_wgt_bits = 4'd4; i_act_signed = 1'b0; i_wgt_signed = 1'b0;
    use_tab = 1'b0; pe_const = 10'sd9; cur_w = 4; i_start = 1'b1;
    @(posedge CLK); #1 i_start = 1'b0;
    cyc = 0; nis = 0;
    while (nis < 3 && cyc < 50) begin
      @(negedge CLK);
      cyc++;
      if (o_issue) nis++;
    end
    chk("abort_reached_third_issue", nis, 3);
    RSTn = 1'b0;
    #1 chk("abort_outputs_zero", longint'({o_issue, o_act_sel, o_wgt_sel, o_SignI, o_SignW, o_busy, o_valid, o_result}), 0);
    @(negedge CLK); RSTn = 1'b1;
    last_r = 0;
    sawv = 1'b0;
    repeat (20) begin
      @(negedge CLK);
      if (o_valid) sawv = 1'b1;
    end
    chk("abort_no_valid", longint'(sawv), 0);
    v = '{ab:4'd1, wb:4'd1, as_:0, ws_:0, pc:7, ea:1, ew:1, stray:0, er:7};
    run(v, 1'b0, "after_abort");

    // 12-bit accumulator overflow.
    m = 0;
    for (int a = 0; a < 4; a++) begin
      for (int w = 0; w < 4; w++) begin
        m = m + (longint'(511) << (a + w));
`ifdef PSUM_SAT_EN
        if (m > 2047)  m = 2047;
        if (m < -2048) m = -2048;
`else
        t12 = m[11:0];
        m = longint'(t12);
`endif
      end
    end
    @(negedge CLK);
    i_act_bits = 4'd4; i_wgt_bits = 4'd4; i_act_signed = 1'b0; i_wgt_signed = 1'b0;
    start12 = 1'b1;
    sb.push_back(m);
    @(posedge CLK); #1 start12 = 1'b0;
    cyc = 0; sawv = 1'b0;
    while (!sawv && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (valid12) sawv = 1'b1;
    end
    chk("ovf_valid_seen", longint'(sawv), 1);
    chk("ovf_latency", cyc, 18);
    if (sb.size() == 0) chk("ovf_sb_nonempty", 0, 1);
    else chk("ovf_result", longint'(res12), sb.pop_front());

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitslice_psum_accum.md
Name: bitslice_psum_accum

Overview:
- Sequencer and accumulator on the far side of the bit-slice PE.
- Steps the PE through every (activation slice, weight slice) pair of one multi-bit operand pair and drives the slice selects and MSB sign flags toward the PE.
- Takes back the PE's registered partial sum one cycle later, shifts it by slice significance and accumulates.
- Emits one full-precision signed result per operation with a valid pulse. Sits between the PE array and the output/psum buffer.

Parameters:
- PSUM_W, 10, width of the signed partial sum returned by the PE.
- ACC_W, 32, width of the signed accumulator and result.
- MAX_ACT_BITS, 8, maximum activation precision (number of 1-bit slices).
- MAX_WGT_BITS, 8, maximum weight precision (number of 1-bit slices).
- SEL_W, 3, width of the slice-index outputs, clog2(max(MAX_ACT_BITS, MAX_WGT_BITS)).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- i_start  in  1  start request, sampled only in IDLE.
- i_act_bits  in  4  activation precision, latched at start.
- i_wgt_bits  in  4  weight precision, latched at start.
- i_act_signed  in  1  activation is two's complement, latched at start.
- i_wgt_signed  in  1  weight is two's complement, latched at start.
- o_issue  out  1  a slice pair is presented to the PE this cycle.
- o_act_sel  out  SEL_W  activation slice index being issued.
- o_wgt_sel  out  SEL_W  weight slice index being issued.
- o_SignI  out  1  activation slice is the signed MSB.
- o_SignW  out  1  weight slice is the signed MSB.
- i_psum  in  PSUM_W  signed registered PE output (one-cycle PE latency).
- o_busy  out  1  operation in progress (state != IDLE).
- o_result  out  ACC_W  signed accumulated result.
- o_valid  out  1  one-cycle pulse, o_result is final.

Behaviour:
- Reset: state IDLE. Accumulator, o_result, o_issue, o_act_sel, o_wgt_sel, o_SignI, o_SignW, o_busy, o_valid and the delayed-shift pipeline all 0. Reset is asynchronous and may occur mid-operation; the operation is abandoned with no o_valid.
- Precision latch: on an accepted start, precision 0 is treated as 1 and values above MAX are clamped to MAX. Call the latched values A and W.
- Start acceptance: i_start is accepted only in IDLE. An accepted start clears the accumulator; o_result holds its old value until the new result is written. i_start while busy is ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE on accepted start.
  - ISSUE: issues N = A*W slice pairs, one per cycle, activation index outer and weight index inner: (0,0), (0,1), ..., (0,W-1), (1,0), ..., (A-1,W-1).
  - ISSUE -> DRAIN after the pair (A-1, W-1).
  - DRAIN -> DONE after one cycle.
  - DONE -> IDLE after one cycle.
- ISSUE outputs: o_issue=1. o_SignI = i_act_signed && (act index == A-1). o_SignW = i_wgt_signed && (wgt index == W-1). Outside ISSUE, o_issue, the select outputs and the sign flags are 0.
- Return path: shift amount s = act index + wgt index and o_issue are registered together one stage, matching the PE's DFFQ. In the cycle after each issue, acc <= acc + (sign-extend(i_psum) <<< s). i_psum is ignored when the delayed issue bit is 0.
- Arithmetic: sign-extend to ACC_W before shifting; addition wraps modulo 2^ACC_W. Slice sign handling is done in the PE; the accumulator always adds.
- Latency: start sampled at edge 0. Issues occupy cycles 1..N; the last accumulate happens at the end of cycle N+1 (DRAIN). In DONE (cycle N+2), o_result = acc and o_valid=1 for exactly one cycle.
- Back-to-back: a start presented in the cycle after DONE (IDLE) is accepted, giving an operation period of N+3 cycles.

Optional Feature:
- PSUM_SAT_EN defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once saturated, the accumulator still moves back toward zero on opposite-signed additions.
- Undefined: two's-complement wrap as specified above.

Test Plan:
- Single pair: A=1, W=1, bench PE model returns psum=5 -> exactly one issue at (0,0) with SignI=SignW=0; o_valid in cycle 3 with o_result=5.
- 2x2 unsigned: A=2, W=2, psums 1, 2, 3, 4 in issue order -> issue order (0,0), (0,1), (1,0), (1,1); o_result=1+4+6+16=27; o_valid in cycle 6.
- Signed flags: A=2, W=3, both signed -> o_SignW=1 only when wgt_sel=2; o_SignI=1 only when act_sel=1. psum=-1 on every pair -> o_result=-(1+2+4)*(1+2)=-21.
- Clamp and busy: i_act_bits=0, i_wgt_bits=15 -> A=1, W=8, 8 issues. Second i_start mid-operation -> ignored, no extra issues.
- Reset mid-operation: assert RSTn=0 during the third issue of a 4x4 run -> all outputs 0 immediately. After release, a new 1x1 run with psum=7 -> o_result=7.
- Overflow with ACC_W=12, A=W=4, all psums=+511 (PSUM_W=10) -> with PSUM_SAT_EN, o_result=2047; without it, o_result equals the wrapped 12-bit sum.
